// File: rtl/alarm_panel.sv
// alarm_panel: keypad alarm target. Collects CODE_LEN-digit entries from the
// code generator stream, arms/disarms on the secret code, latches an alarm on
// sensor trip while armed, and locks the keypad out after MAX_FAILS
// consecutive wrong entries.
//
// Handshake: there is no back-pressure. A digit is consumed on every rising
// edge where digit_entered=1 and command is ARM/DISARM/CLEAR; digit_entered
// may stay high for back-to-back digits. All outputs are registered and
// reflect the action sampled at the previous edge.
`timescale 1ns/1ps
module alarm_panel #(
    parameter int                    CODE_LEN       = 3,
    parameter logic [4*CODE_LEN-1:0] SECRET         = 12'h427,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] command,
    input  logic [3:0] digit,
    input  logic       digit_entered,
    input  logic       sensor,
    output logic       armed,
    output logic       alarm,
    output logic       locked,
    output logic       code_ok,
    output logic       code_bad,
    output logic [3:0] fail_count,
    output logic [1:0] dbg_state_o
);

    localparam int BW = 4 * CODE_LEN;
    localparam int PW = 3;
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_ARM    = 2'b01;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENTRY   = 2'd1;
    localparam logic [1:0] ST_LOCKOUT = 2'd2;

    localparam logic [PW-1:0] LAST_POS  = PW'(CODE_LEN);
    localparam logic [3:0]    MAX_CNT   = 4'(MAX_FAILS);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);

    logic [1:0]    state_q,  state_d;
    logic [BW-1:0] buf_q,    buf_d;
    logic [PW-1:0] pos_q,    pos_d;
    logic [1:0]    cmd_q,    cmd_d;
    logic [TW-1:0] timer_q,  timer_d;
    logic          armed_q,  armed_d;
    logic          alarm_q,  alarm_d;
    logic          locked_q, locked_d;
    logic          ok_q,     ok_d;
    logic          bad_q,    bad_d;
    logic [3:0]    fail_q,   fail_d;

    logic [BW-1:0] new_buf;
    logic [PW-1:0] new_pos;
    logic [3:0]    fail_inc;

    // Next-state logic: entry collection, completion decode, lockout timer, alarm latch.
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        pos_d    = pos_q;
        cmd_d    = cmd_q;
        timer_d  = timer_q;
        armed_d  = armed_q;
        locked_d = locked_q;
        fail_d   = fail_q;
        ok_d     = 1'b0;
        bad_d    = 1'b0;
        new_buf  = '0;
        new_pos  = '0;
        fail_inc = (fail_q >= MAX_CNT) ? MAX_CNT : fail_q + 4'd1;

        // Sensor only matters while armed; a correct DISARM below overrides it.
        alarm_d  = alarm_q | (armed_q & sensor);

        if (state_q == ST_LOCKOUT) begin
            // Keypad is dead, CLEAR included, until the timer runs out.
            if (timer_q <= TIMER_ONE) begin
                state_d  = ST_IDLE;
                timer_d  = '0;
                locked_d = 1'b0;
                fail_d   = 4'd0;
            end else begin
                timer_d = timer_q - TIMER_ONE;
            end
        end else if (digit_entered) begin
            if (command == CMD_CLEAR) begin
                buf_d   = '0;
                pos_d   = '0;
                state_d = ST_IDLE;
            end else if (command != CMD_NOP) begin
                // A command switch mid-entry restarts the entry at this digit.
                if (pos_q == '0 || command != cmd_q) begin
                    new_buf = BW'(digit);
                    new_pos = PW'(1);
                end else begin
                    new_buf = (buf_q << 4) | BW'(digit);
                    new_pos = pos_q + PW'(1);
                end
                cmd_d = command;

                if (new_pos == LAST_POS) begin
                    buf_d   = '0;
                    pos_d   = '0;
                    state_d = ST_IDLE;
                    if (new_buf == SECRET) begin
                        // Any correct entry breaks the run of consecutive failures.
                        ok_d   = 1'b1;
                        fail_d = 4'd0;
                        if (command == CMD_ARM) begin
                            armed_d = 1'b1;
                        end else begin
                            armed_d = 1'b0;
                            alarm_d = 1'b0;
                        end
                    end else begin
                        bad_d  = 1'b1;
                        fail_d = fail_inc;
                        if (fail_inc == MAX_CNT) begin
                            state_d  = ST_LOCKOUT;
                            locked_d = 1'b1;
                            timer_d  = LOCK_LOAD;
                            if (armed_q) begin
                                alarm_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    buf_d   = new_buf;
                    pos_d   = new_pos;
                    state_d = ST_ENTRY;
                end
            end
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            buf_q    <= '0;
            pos_q    <= '0;
            cmd_q    <= CMD_NOP;
            timer_q  <= '0;
            armed_q  <= 1'b0;
            alarm_q  <= 1'b0;
            locked_q <= 1'b0;
            ok_q     <= 1'b0;
            bad_q    <= 1'b0;
            fail_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            pos_q    <= pos_d;
            cmd_q    <= cmd_d;
            timer_q  <= timer_d;
            armed_q  <= armed_d;
            alarm_q  <= alarm_d;
            locked_q <= locked_d;
            ok_q     <= ok_d;
            bad_q    <= bad_d;
            fail_q   <= fail_d;
        end
    end

    assign armed       = armed_q;
    assign alarm       = alarm_q;
    assign locked      = locked_q;
    assign code_ok     = ok_q;
    assign code_bad    = bad_q;
    assign fail_count  = fail_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alarm_panel.sv
// tb_alarm_panel: table-driven vectors, hand-written multi-cycle sequences,
// a generator-style brute-force sweep and random traffic for alarm_panel,
// all checked against a digit-queue reference model.
`timescale 1ns/1ps
module tb_alarm_panel;

    localparam int CODE_LEN       = 3;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 16;

    localparam logic [1:0] C_NOP = 2'b00;
    localparam logic [1:0] C_ARM = 2'b01;
    localparam logic [1:0] C_DIS = 2'b10;
    localparam logic [1:0] C_CLR = 2'b11;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] command = C_NOP;
    logic [3:0] digit = 4'd0;
    logic       digit_entered = 1'b0;
    logic       sensor = 1'b0;
    logic       armed, alarm, locked, code_ok, code_bad;
    logic [3:0] fail_count;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    alarm_panel #(
        .CODE_LEN(CODE_LEN), .SECRET(12'h427),
        .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .command(command), .digit(digit),
        .digit_entered(digit_entered), .sensor(sensor),
        .armed(armed), .alarm(alarm), .locked(locked),
        .code_ok(code_ok), .code_bad(code_bad), .fail_count(fail_count),
        .dbg_state_o(dbg_state)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int busy_cycles = 0;
    int ok_seen = 0;

    always @(posedge clk) if (dbg_state != 2'd0) busy_cycles++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Entry kept as a list of digits; compared digit-by-digit to the secret.
    int   secret_d[CODE_LEN] = '{4, 2, 7};
    int   dq[$];
    logic [1:0] m_cmd;
    bit   m_armed, m_alarm, m_locked, m_ok, m_bad;
    int   m_fail, m_left;

    task automatic model_reset();
        dq.delete();
        m_cmd = C_NOP;
        m_armed = 0; m_alarm = 0; m_locked = 0; m_ok = 0; m_bad = 0;
        m_fail = 0; m_left = 0;
    endtask

    task automatic model_step(input logic [1:0] cmd, input logic [3:0] dg,
                              input bit de, input bit sen);
        bit sensor_hit, disarm_win, lock_alarm, match;
        sensor_hit = m_armed && sen;
        disarm_win = 0;
        lock_alarm = 0;
        m_ok = 0;
        m_bad = 0;
        if (m_locked) begin
            m_left--;
            if (m_left == 0) begin
                m_locked = 0;
                m_fail = 0;
            end
        end else if (de) begin
            if (cmd == C_CLR) begin
                dq.delete();
            end else if (cmd != C_NOP) begin
                if (dq.size() > 0 && cmd != m_cmd) dq.delete();
                m_cmd = cmd;
                dq.push_back(int'(dg));
                if (dq.size() == CODE_LEN) begin
                    match = 1;
                    for (int i = 0; i < CODE_LEN; i++)
                        if (dq[i] != secret_d[i]) match = 0;
                    dq.delete();
                    if (match) begin
                        m_ok = 1;
                        m_fail = 0;
                        if (cmd == C_ARM) begin
                            m_armed = 1;
                        end else begin
                            disarm_win = 1;
                            m_armed = 0;
                        end
                    end else begin
                        m_bad = 1;
                        m_fail = (m_fail + 1 > MAX_FAILS) ? MAX_FAILS : m_fail + 1;
                        if (m_fail == MAX_FAILS) begin
                            m_locked = 1;
                            m_left = LOCKOUT_CYCLES;
                            if (m_armed) lock_alarm = 1;
                        end
                    end
                end
            end
        end
        if (disarm_win) m_alarm = 0;
        else if (sensor_hit || lock_alarm) m_alarm = 1;
    endtask

    function automatic logic [8:0] model_vec();
        return {m_armed, m_alarm, m_locked, m_ok, m_bad, 4'(m_fail)};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {armed, alarm, locked, code_ok, code_bad, fail_count};
    endfunction

    function automatic logic [8:0] ev(bit a, bit al, bit lk, bit ok, bit bad, int f);
        return {a, al, lk, ok, bad, 4'(f)};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_vec(input string name, input logic [8:0] exp);
        logic [8:0] got;
        got = dut_vec();
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s @%0t: got armed=%0b alarm=%0b locked=%0b ok=%0b bad=%0b fail=%0d, expected armed=%0b alarm=%0b locked=%0b ok=%0b bad=%0b fail=%0d",
                     name, $time, got[8], got[7], got[6], got[5], got[4], got[3:0],
                     exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    // ---------------- driver ----------------
    // Drive inputs, take one edge, step the model, sample 1ns later.
    task automatic cycle(input logic [1:0] cmd, input logic [3:0] dg,
                         input bit de, input bit sen, input string name);
        command = cmd;
        digit = dg;
        digit_entered = de;
        sensor = sen;
        @(posedge clk);
        model_step(cmd, dg, de, sen);
        #1;
        if (code_ok) ok_seen++;
        check_vec(name, model_vec());
    endtask

    task automatic enter3(input logic [1:0] cmd, input int a, input int b, input int c,
                          input string name);
        cycle(cmd, 4'(a), 1, 0, name);
        cycle(cmd, 4'(b), 1, 0, name);
        cycle(cmd, 4'(c), 1, 0, name);
    endtask

    // Reset raised and released between edges; outputs must clear at once.
    task automatic async_reset(input string name);
        digit_entered = 0;
        command = C_NOP;
        sensor = 0;
        #2 reset = 1;
        #1 check_vec(name, 9'd0);
        #1 reset = 0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] cmd;
        logic [3:0] dg;
        bit         de;
        bit         sen;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] cmd, int dg, bit de, bit sen, logic [8:0] exp);
        vec_t v;
        v.cmd = cmd; v.dg = 4'(dg); v.de = de; v.sen = sen; v.exp = exp;
        return v;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_vec("reset_state", 9'd0);
        @(negedge clk) reset = 0;

        // Correct arm/disarm, command switch, NOP/CLEAR, sensor, re-arm.
        tbl.push_back(mk(C_ARM, 4, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 2, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 7, 1, 0, ev(1,0,0,1,0,0)));
        tbl.push_back(mk(C_DIS, 4, 1, 0, ev(1,0,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 2, 1, 0, ev(1,0,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 7, 1, 0, ev(0,0,0,1,0,0)));
        tbl.push_back(mk(C_ARM, 4, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 2, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 4, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 2, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 7, 1, 0, ev(0,0,0,1,0,0)));
        tbl.push_back(mk(C_ARM, 1, 0, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_NOP, 4, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 4, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 2, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_CLR, 0, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 7, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 0, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 0, 1, 0, ev(0,0,0,0,1,1)));
        tbl.push_back(mk(C_ARM, 4, 1, 0, ev(0,0,0,0,0,1)));
        tbl.push_back(mk(C_ARM, 2, 1, 0, ev(0,0,0,0,0,1)));
        tbl.push_back(mk(C_ARM, 7, 1, 0, ev(1,0,0,1,0,0)));
        tbl.push_back(mk(C_NOP, 0, 0, 1, ev(1,1,0,0,0,0)));
        tbl.push_back(mk(C_NOP, 0, 0, 0, ev(1,1,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 4, 1, 0, ev(1,1,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 2, 1, 0, ev(1,1,0,0,0,0)));
        tbl.push_back(mk(C_ARM, 7, 1, 0, ev(1,1,0,1,0,0)));
        tbl.push_back(mk(C_DIS, 4, 1, 0, ev(1,1,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 2, 1, 0, ev(1,1,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 7, 1, 1, ev(0,0,0,1,0,0)));
        tbl.push_back(mk(C_NOP, 0, 0, 1, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 10, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 2, 1, 0, ev(0,0,0,0,0,0)));
        tbl.push_back(mk(C_DIS, 7, 1, 0, ev(0,0,0,0,1,1)));
        tbl.push_back(mk(C_DIS, 4, 1, 0, ev(0,0,0,0,0,1)));
        tbl.push_back(mk(C_DIS, 2, 1, 0, ev(0,0,0,0,0,1)));
        tbl.push_back(mk(C_DIS, 7, 1, 0, ev(0,0,0,1,0,0)));

        foreach (tbl[i]) begin
            cycle(tbl[i].cmd, tbl[i].dg, tbl[i].de, tbl[i].sen, "table_model");
            check_vec($sformatf("table_row_%0d", i), tbl[i].exp);
        end

        // Wrong codes while armed -> lockout with alarm; keypad ignored 16 cycles.
        enter3(C_ARM, 4, 2, 7, "lock_arm");
        check_vec("lock_armed", ev(1,0,0,1,0,0));
        for (int k = 0; k < MAX_FAILS; k++) begin
            enter3(C_DIS, 0, 0, 0, "lock_wrong");
            check_vec($sformatf("lock_wrong_%0d", k + 1),
                      ev(1, k == MAX_FAILS - 1, k == MAX_FAILS - 1, 0, 1, k + 1));
        end
        for (int i = 1; i <= LOCKOUT_CYCLES; i++) begin
            cycle(i == 1 ? C_CLR : C_DIS, 4'(secret_d[i % 3]), 1, 0, "lock_hold");
            if (i < LOCKOUT_CYCLES)
                check_vec($sformatf("lock_hold_%0d", i), ev(1,1,1,0,0,MAX_FAILS));
            else
                check_vec("lock_release", ev(1,1,0,0,0,0));
        end
        enter3(C_DIS, 4, 2, 7, "lock_after");
        check_vec("lock_after_disarm", ev(0,0,0,1,0,0));

        // Async reset mid-entry: interrupted digits are forgotten.
        enter3(C_ARM, 4, 2, 7, "rst_arm");
        cycle(C_ARM, 4, 1, 0, "rst_entry");
        cycle(C_ARM, 2, 1, 0, "rst_entry");
        async_reset("rst_mid_entry");
        cycle(C_ARM, 2, 1, 0, "rst_resume");
        cycle(C_ARM, 7, 1, 0, "rst_resume");
        check_vec("rst_no_short_entry", ev(0,0,0,0,0,0));
        cycle(C_ARM, 4, 1, 0, "rst_resume");
        check_vec("rst_full_entry_bad", ev(0,0,0,0,1,1));
        enter3(C_ARM, 4, 2, 7, "rst_rearm");
        check_vec("rst_rearm_ok", ev(1,0,0,1,0,0));

        // Async reset during lockout.
        for (int k = 0; k < MAX_FAILS; k++) enter3(C_DIS, 9, 9, 9, "rst_lock_wrong");
        check_vec("rst_lock_entered", ev(1,1,1,0,1,MAX_FAILS));
        cycle(C_NOP, 0, 0, 0, "rst_lock_wait");
        cycle(C_NOP, 0, 0, 0, "rst_lock_wait");
        async_reset("rst_mid_lockout");
        enter3(C_ARM, 4, 2, 7, "rst_lock_after");
        check_vec("rst_lock_after_ok", ev(1,0,0,1,0,0));

        // Generator-style sweep: DISARM held, ascending codes 000..999.
        async_reset("sweep_reset");
        ok_seen = 0;
        for (int code = 0; code < 1000; code++) begin
            cycle(C_DIS, 4'(code / 100), 1, 0, "sweep");
            cycle(C_DIS, 4'((code / 10) % 10), 1, 0, "sweep");
            cycle(C_DIS, 4'(code % 10), 1, 0, "sweep");
            if (code == 2) check_vec("sweep_first_lockout", ev(0,0,1,0,1,MAX_FAILS));
        end
        $display("info: sweep code_ok pulses = %0d", ok_seen);

        // Random traffic biased towards secret digits, with occasional resets.
        async_reset("rand_reset");
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [1:0] c;
            logic [3:0] d;
            r = $urandom_range(0, 9);
            c = (r == 0) ? C_NOP : (r == 1) ? C_CLR : (r < 6) ? C_ARM : C_DIS;
            d = ($urandom_range(0, 9) < 7) ? 4'(secret_d[$urandom_range(0, 2)])
                                           : 4'($urandom_range(0, 15));
            cycle(c, d, $urandom_range(0, 4) != 0, $urandom_range(0, 15) == 0, "random");
            if ($urandom_range(0, 299) == 0) async_reset("random_reset");
        end

        $display("info: non-idle cycles = %0d", busy_cycles);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
